// File: rtl/multicycle_alu_pkg.sv
// Shared ALU definitions: opcode encodings (also decoded by the control unit),
// FSM state encoding and the fixed single-cycle latency.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_MUL = 6'b000010;
    localparam logic [5:0] OP_DIV = 6'b000011;
    localparam logic [5:0] OP_AND = 6'b000100;
    localparam logic [5:0] OP_OR  = 6'b000101;
    localparam logic [5:0] OP_XOR = 6'b000110;
    localparam logic [5:0] OP_NOT = 6'b000111;
    localparam logic [5:0] OP_FFT = 6'b001000;
    localparam logic [5:0] OP_ENC = 6'b001001;
    localparam logic [5:0] OP_DEC = 6'b001010;

    localparam int ALU_LAT_SINGLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Start/busy/done request bus between the operand source and the ALU.
// master issues start with operands; slave reports busy, done and the held result.
interface multicycle_alu_if #(
    parameter int WIDTH = 19,
    parameter int OPW   = 6
);
    logic             start;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             dbz;

    modport master (output start, opcode, a, b,
                    input  busy, done, result, zero, dbz);
    modport slave  (input  start, opcode, a, b,
                    output busy, done, result, zero, dbz);
endinterface

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative MUL (shift-add, LSB first) / DIV (restoring) engine, one bit per clock for WIDTH clocks.
// step_done flags the final step; q is the value that step produces, so the caller can register it then.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             step_done,
    output logic [WIDTH-1:0] q
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH:0]   r_acc;

    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_opnd_nxt;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;

    // r_sh is the multiplier (shifts right) or the dividend/quotient (shifts left);
    // r_acc is the product accumulator or the partial remainder.
    always_comb begin
        w_rem_sh   = {r_acc[WIDTH-1:0], r_sh[WIDTH-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_opnd});
        w_sh_nxt   = r_sh;
        w_opnd_nxt = r_opnd;
        w_acc_nxt  = r_acc;
        if (r_div) begin
            w_sh_nxt  = {r_sh[WIDTH-2:0], w_ge};
            w_acc_nxt = w_ge ? (w_rem_sh - {1'b0, r_opnd}) : w_rem_sh;
        end else begin
            w_sh_nxt   = r_sh >> 1;
            w_opnd_nxt = r_opnd << 1;
            w_acc_nxt  = r_sh[0] ? (r_acc + {1'b0, r_opnd}) : r_acc;
        end
    end

    assign step_done = (r_cnt == CW'(1));
    assign q         = r_div ? w_sh_nxt : w_acc_nxt[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_sh   <= '0;
            r_opnd <= '0;
            r_acc  <= '0;
        end else if (load) begin
            r_cnt  <= CW'(WIDTH);
            r_div  <= is_div;
            r_sh   <= is_div ? a : b;
            r_opnd <= is_div ? b : a;
            r_acc  <= '0;
        end else if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CW'(1);
            r_sh   <= w_sh_nxt;
            r_opnd <= w_opnd_nxt;
            r_acc  <= w_acc_nxt;
        end
    end
endmodule

// File: rtl/multicycle_alu.sv
// Sequential ALU: logic/add ops and DIV-by-zero finish in 1 cycle, MUL/DIV in WIDTH+1 cycles.
// No queueing: start is accepted only while busy=0 (IDLE or DONE); result is held until the next done.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int OPW   = 6
) (
    input  logic clk,
    input  logic rst,
    multicycle_alu_if.slave bus
);
    alu_state_t       r_state;
    alu_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_dbz;

    logic [WIDTH-1:0] w_single;
    logic             w_iter;
    logic             w_dbz;
    logic             w_is_div;
    logic             w_accept;
    logic             w_load;
    logic             w_step_done;
    logic [WIDTH-1:0] w_md_q;

    always_comb begin
        w_single = '0;
        w_iter   = 1'b0;
        w_dbz    = 1'b0;
        case (bus.opcode)
            OPW'(OP_ADD): w_single = bus.a + bus.b;
            OPW'(OP_SUB): w_single = bus.a - bus.b;
            OPW'(OP_MUL): w_iter   = 1'b1;
            OPW'(OP_DIV): begin
                if (bus.b == '0) begin
                    w_single = '1;
                    w_dbz    = 1'b1;
                end else begin
                    w_iter = 1'b1;
                end
            end
            OPW'(OP_AND): w_single = bus.a & bus.b;
            OPW'(OP_OR):  w_single = bus.a | bus.b;
            OPW'(OP_XOR): w_single = bus.a ^ bus.b;
            OPW'(OP_NOT): w_single = ~bus.a;
            OPW'(OP_FFT), OPW'(OP_ENC), OPW'(OP_DEC): w_single = bus.a;
            default:      w_single = '0;
        endcase
    end

    assign w_is_div = (bus.opcode == OPW'(OP_DIV));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_load      = w_iter;
                    w_state_nxt = w_iter ? ST_ITER : ST_DONE;
                end
            end
            ST_ITER: if (w_step_done) w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .is_div    (w_is_div),
        .a         (bus.a),
        .b         (bus.b),
        .step_done (w_step_done),
        .q         (w_md_q)
    );

    // Results are written on the edge that enters DONE, so they are valid with the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_dbz    <= 1'b0;
        end else if (w_accept && !w_iter) begin
            r_result <= w_single;
            r_zero   <= (w_single == '0);
            r_dbz    <= w_dbz;
        end else if ((r_state == ST_ITER) && w_step_done) begin
            r_result <= w_md_q;
            r_zero   <= (w_md_q == '0);
            r_dbz    <= 1'b0;
        end
    end

    assign bus.busy   = (r_state == ST_ITER);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.dbz    = r_dbz;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=19: latency, arithmetic, handshake and reset abort.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int W = 19;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(W), .OPW(6)) bus ();

    multicycle_alu #(.WIDTH(W), .OPW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int lat;
    int busy_cnt;
    int done_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble operands after accept, then count cycles until done.
    task automatic run_op(input logic [5:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.a = av; bus.b = bv;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 19'h5A5A5; bus.b = 19'h00003;
        lat = 1; busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_zero",   32'(bus.zero),   32'd1);
        chk("rst_dbz",    32'(bus.dbz),    32'd0);
        rst = 1'b1;

        run_op(OP_ADD, 19'd5, 19'd7);
        chk("add_lat",  32'(lat),        32'd1);
        chk("add_res",  32'(bus.result), 32'd12);
        chk("add_zero", 32'(bus.zero),   32'd0);
        chk("add_busy", 32'(busy_cnt),   32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);

        run_op(OP_SUB, 19'd3, 19'd3);
        chk("sub_res0",  32'(bus.result), 32'd0);
        chk("sub_zero1", 32'(bus.zero),   32'd1);
        run_op(OP_SUB, 19'd0, 19'd1);
        chk("sub_wrap",  32'(bus.result), 32'h7FFFF);
        chk("sub_zero0", 32'(bus.zero),   32'd0);

        run_op(OP_MUL, 19'd1000, 19'd1000);
        chk("mul_lat",  32'(lat),        32'd20);
        chk("mul_busy", 32'(busy_cnt),   32'd19);
        chk("mul_res",  32'(bus.result), 32'd475712);
        chk("mul_zero", 32'(bus.zero),   32'd0);

        run_op(OP_DIV, 19'd100, 19'd7);
        chk("div_lat", 32'(lat),        32'd20);
        chk("div_res", 32'(bus.result), 32'd14);
        chk("div_dbz", 32'(bus.dbz),    32'd0);

        run_op(OP_DIV, 19'd9, 19'd0);
        chk("dbz_lat",  32'(lat),        32'd1);
        chk("dbz_res",  32'(bus.result), 32'h7FFFF);
        chk("dbz_flag", 32'(bus.dbz),    32'd1);
        chk("dbz_busy", 32'(busy_cnt),   32'd0);

        run_op(OP_AND, 19'h00F0F, 19'h000FF);
        chk("and_res", 32'(bus.result), 32'h0000F);
        chk("and_dbz", 32'(bus.dbz),    32'd0);
        run_op(OP_OR,  19'h00F0F, 19'h000FF);
        chk("or_res",  32'(bus.result), 32'h00FFF);
        run_op(OP_XOR, 19'h00F0F, 19'h000FF);
        chk("xor_res", 32'(bus.result), 32'h00FF0);
        run_op(OP_NOT, 19'h12345, 19'h0);
        chk("not_res", 32'(bus.result), 32'h6DCBA);
        run_op(OP_ENC, 19'h2AAAA, 19'h11111);
        chk("enc_res", 32'(bus.result), 32'h2AAAA);
        run_op(6'b111111, 19'h1234, 19'h5678);
        chk("unk_res",  32'(bus.result), 32'd0);
        chk("unk_zero", 32'(bus.zero),   32'd1);

        // Second MUL requested mid-ITER is dropped; a start in the DONE cycle is taken.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.a = 19'd1000; bus.b = 19'd1000;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                bus.start = 1'b1; bus.opcode = OP_MUL; bus.a = 19'd2; bus.b = 19'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk("ign_lat", 32'(lat),        32'd20);
        chk("ign_res", 32'(bus.result), 32'd475712);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.a = 19'd2; bus.b = 19'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_accept", 32'(bus.busy), 32'd1);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat", 32'(lat),        32'd20);
        chk("b2b_res", 32'(bus.result), 32'd6);

        // Abort a MUL at cycle 8 with reset.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.a = 19'd1000; bus.b = 19'd1000;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) @(negedge clk);
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy",   32'(bus.busy),   32'd0);
        chk("abort_done",   32'(bus.done),   32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_zero",   32'(bus.zero),   32'd1);
        chk("abort_dbz",    32'(bus.dbz),    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_idle",    32'(bus.busy), 32'd0);

        run_op(OP_ADD, 19'd1, 19'd1);
        chk("post_rst_lat", 32'(lat),        32'd1);
        chk("post_rst_res", 32'(bus.result), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
